// File: rtl/vending_machine_param.sv
// Parameterized soda vending machine.
// Coins add credit in nickel units. Reaching PRICE dispenses one soda.
// Any remaining credit is then returned greedily, one coin per cycle.
// Every output is a registered Moore output of the next state and credit,
// so no output depends combinationally on the current inputs.
module vending_machine_param #(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                nickel_i,
    input  logic                dime_i,
    input  logic                quarter_i,
    input  logic                cancel_i,
    output logic                soda_o,
    output logic                chg_nickel_o,
    output logic                chg_dime_o,
    output logic                chg_quarter_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy_o,
    output logic                coin_reject_o
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2,
        REFUND  = 2'd3
    } state_e;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ZERO_C  = '0;
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(5);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                soda_q, soda_d;
    logic                chg_nickel_q, chg_nickel_d;
    logic                chg_dime_q, chg_dime_d;
    logic                chg_quarter_q, chg_quarter_d;
    logic                busy_q, busy_d;
    logic                coin_reject_q, coin_reject_d;

    logic                coin_any;
    logic                coin_onehot;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] eject_val;

    // Decode the coin inputs; a coin counts only when exactly one line is high.
    always_comb begin
        coin_any    = nickel_i | dime_i | quarter_i;
        coin_onehot = (nickel_i ^ dime_i ^ quarter_i) & ~(nickel_i & dime_i & quarter_i);
        coin_val    = ZERO_C;
        if (nickel_i)       coin_val = ONE_C;
        else if (dime_i)    coin_val = TWO_C;
        else if (quarter_i) coin_val = FIVE_C;
    end

    // Pick the largest coin that fits the current credit for change and refund.
    always_comb begin
        if (credit_q >= FIVE_C)     eject_val = FIVE_C;
        else if (credit_q >= TWO_C) eject_val = TWO_C;
        else                        eject_val = ONE_C;
    end

    // Compute the next state and credit, then derive the next output values.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = 1'b0;

        case (state_q)
            COLLECT: begin
                if (cancel_i) begin
                    // Cancel takes priority over any coin sampled in the same cycle.
                    coin_reject_d = coin_any;
                    if (credit_q != ZERO_C) state_d = REFUND;
                end else if (coin_onehot) begin
                    // Credit before the add is at most PRICE-1, so the sum is at
                    // most PRICE+4 and cannot wrap.
                    credit_d = credit_q + coin_val;
                    if (credit_d >= PRICE_C) state_d = VEND;
                end else begin
                    coin_reject_d = coin_any;
                end
            end
            VEND: begin
                coin_reject_d = coin_any;
                credit_d      = credit_q - PRICE_C;
                state_d       = (credit_d != ZERO_C) ? CHANGE : COLLECT;
            end
            CHANGE, REFUND: begin
                coin_reject_d = coin_any;
                if (credit_q == ZERO_C) begin
                    state_d = COLLECT;
                end else begin
                    credit_d = credit_q - eject_val;
                    if (credit_d == ZERO_C) state_d = COLLECT;
                end
            end
            default: begin
                state_d  = COLLECT;
                credit_d = ZERO_C;
            end
        endcase

        // Outputs are Moore functions of the upcoming state and credit, registered.
        soda_d        = (state_d == VEND);
        busy_d        = (state_d != COLLECT);
        chg_quarter_d = 1'b0;
        chg_dime_d    = 1'b0;
        chg_nickel_d  = 1'b0;
        if ((state_d == CHANGE || state_d == REFUND) && credit_d != ZERO_C) begin
            if (credit_d >= FIVE_C)     chg_quarter_d = 1'b1;
            else if (credit_d >= TWO_C) chg_dime_d    = 1'b1;
            else                        chg_nickel_d  = 1'b1;
        end
    end

    // State, credit and output registers, with a synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= COLLECT;
            credit_q      <= ZERO_C;
            soda_q        <= 1'b0;
            chg_nickel_q  <= 1'b0;
            chg_dime_q    <= 1'b0;
            chg_quarter_q <= 1'b0;
            busy_q        <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            soda_q        <= soda_d;
            chg_nickel_q  <= chg_nickel_d;
            chg_dime_q    <= chg_dime_d;
            chg_quarter_q <= chg_quarter_d;
            busy_q        <= busy_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign soda_o        = soda_q;
    assign chg_nickel_o  = chg_nickel_q;
    assign chg_dime_o    = chg_dime_q;
    assign chg_quarter_o = chg_quarter_q;
    assign credit_o      = credit_q;
    assign busy_o        = busy_q;
    assign coin_reject_o = coin_reject_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param.
// dut uses PRICE=4 and dut1 uses PRICE=1; both share the same stimulus.
// Output vector bits: {soda, chg_quarter, chg_dime, chg_nickel, busy, coin_reject}.
module tb_vending_machine_param;

    logic       clk = 1'b0;
    logic       rst_n, nickel, dime, quarter, cancel;
    logic       soda, chg_n, chg_d, chg_q, busy, rej;
    logic       soda1, chg_n1, chg_d1, chg_q1, busy1, rej1;
    logic [5:0] credit, credit1;
    logic [5:0] outv, outv1;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign outv  = {soda, chg_q, chg_d, chg_n, busy, rej};
    assign outv1 = {soda1, chg_q1, chg_d1, chg_n1, busy1, rej1};

    vending_machine_param #(.PRICE(4), .CREDIT_W(6)) dut (
        .clk_i(clk), .rst_ni(rst_n), .nickel_i(nickel), .dime_i(dime),
        .quarter_i(quarter), .cancel_i(cancel), .soda_o(soda),
        .chg_nickel_o(chg_n), .chg_dime_o(chg_d), .chg_quarter_o(chg_q),
        .credit_o(credit), .busy_o(busy), .coin_reject_o(rej));

    vending_machine_param #(.PRICE(1), .CREDIT_W(6)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .nickel_i(nickel), .dime_i(dime),
        .quarter_i(quarter), .cancel_i(cancel), .soda_o(soda1),
        .chg_nickel_o(chg_n1), .chg_dime_o(chg_d1), .chg_quarter_o(chg_q1),
        .credit_o(credit1), .busy_o(busy1), .coin_reject_o(rej1));

    // Drive one cycle of inputs, let one rising edge pass, sample #1 later, then idle the inputs.
    task automatic drive(input logic n, input logic d, input logic q, input logic c);
        nickel = n; dime = d; quarter = q; cancel = c;
        @(posedge clk); #1;
        nickel = 0; dime = 0; quarter = 0; cancel = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive(0, 0, 0, 0);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(0, 0, 1, 1);
        n_cmp++;
        if (outv !== 6'b000000 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL reset: out=%b cr=%0d, want 000000 cr=0", outv, credit);
        end
        n_cmp++;
        if (outv1 !== 6'b000000 || credit1 !== 6'd0) begin
            n_err++;
            $display("FAIL reset_p1: out=%b cr=%0d, want 000000 cr=0", outv1, credit1);
        end
        rst_n = 1;
    endtask

    task automatic test_nickels();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 0, 0);
            n_cmp++;
            if (outv !== ((i == 4) ? 6'b100010 : 6'b000000) || credit !== 6'(i)) begin
                n_err++;
                $display("FAIL nickels_%0d: out=%b cr=%0d, want cr=%0d", i, outv, credit, i);
            end
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b000000 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL nickels_done: out=%b cr=%0d, want 000000 cr=0", outv, credit);
        end
    endtask

    task automatic test_change();
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        n_cmp++;
        if (outv !== 6'b100010 || credit !== 6'd6) begin
            n_err++;
            $display("FAIL change_vend: out=%b cr=%0d, want 100010 cr=6", outv, credit);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b001010 || credit !== 6'd2) begin
            n_err++;
            $display("FAIL change_dime: out=%b cr=%0d, want 001010 cr=2", outv, credit);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b000000 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL change_done: out=%b cr=%0d, want 000000 cr=0", outv, credit);
        end
    endtask

    task automatic test_max_credit();
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        n_cmp++;
        if (outv !== 6'b100010 || credit !== 6'd8) begin
            n_err++;
            $display("FAIL max_vend: out=%b cr=%0d, want 100010 cr=8", outv, credit);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b001010 || credit !== 6'd4) begin
            n_err++;
            $display("FAIL max_dime1: out=%b cr=%0d, want 001010 cr=4", outv, credit);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b001010 || credit !== 6'd2) begin
            n_err++;
            $display("FAIL max_dime2: out=%b cr=%0d, want 001010 cr=2", outv, credit);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b000000 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL max_done: out=%b cr=%0d, want 000000 cr=0", outv, credit);
        end
    endtask

    task automatic test_refund();
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 1);
        n_cmp++;
        if (outv !== 6'b001010 || credit !== 6'd2) begin
            n_err++;
            $display("FAIL refund_dime: out=%b cr=%0d, want 001010 cr=2", outv, credit);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b000000 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL refund_done: out=%b cr=%0d, want 000000 cr=0", outv, credit);
        end
        drive(0, 0, 0, 1);
        n_cmp++;
        if (outv !== 6'b000000 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL cancel_zero: out=%b cr=%0d, want 000000 cr=0", outv, credit);
        end
    endtask

    task automatic test_cancel_coin();
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 1);
        n_cmp++;
        if (outv !== 6'b001011 || credit !== 6'd2) begin
            n_err++;
            $display("FAIL cancel_coin: out=%b cr=%0d, want 001011 cr=2", outv, credit);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b000000 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL cancel_coin_done: out=%b cr=%0d, want 000000 cr=0", outv, credit);
        end
    endtask

    task automatic test_reject();
        drive(0, 1, 1, 0);
        n_cmp++;
        if (outv !== 6'b000001 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL multihot: out=%b cr=%0d, want 000001 cr=0", outv, credit);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b000000 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL reject_pulse: out=%b cr=%0d, want 000000 cr=0", outv, credit);
        end
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b001010 || credit !== 6'd2) begin
            n_err++;
            $display("FAIL rej_setup: out=%b cr=%0d, want 001010 cr=2", outv, credit);
        end
        drive(1, 0, 0, 1);
        n_cmp++;
        if (outv !== 6'b000001 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL busy_coin: out=%b cr=%0d, want 000001 cr=0", outv, credit);
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_price1();
        do_reset();
        drive(0, 0, 1, 0);
        n_cmp++;
        if (outv1 !== 6'b100010 || credit1 !== 6'd5) begin
            n_err++;
            $display("FAIL p1_vend: out=%b cr=%0d, want 100010 cr=5", outv1, credit1);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv1 !== 6'b001010 || credit1 !== 6'd4) begin
            n_err++;
            $display("FAIL p1_dime1: out=%b cr=%0d, want 001010 cr=4", outv1, credit1);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv1 !== 6'b001010 || credit1 !== 6'd2) begin
            n_err++;
            $display("FAIL p1_dime2: out=%b cr=%0d, want 001010 cr=2", outv1, credit1);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv1 !== 6'b000000 || credit1 !== 6'd0) begin
            n_err++;
            $display("FAIL p1_done: out=%b cr=%0d, want 000000 cr=0", outv1, credit1);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b001010 || credit !== 6'd2) begin
            n_err++;
            $display("FAIL mid_setup: out=%b cr=%0d, want 001010 cr=2", outv, credit);
        end
        rst_n = 0;
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b000000 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL mid_reset: out=%b cr=%0d, want 000000 cr=0", outv, credit);
        end
        rst_n = 1;
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b000000 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL mid_after: out=%b cr=%0d, want 000000 cr=0", outv, credit);
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        n_cmp++;
        if (outv !== 6'b100010 || credit !== 6'd4) begin
            n_err++;
            $display("FAIL b2b_vend1: out=%b cr=%0d, want 100010 cr=4", outv, credit);
        end
        drive(0, 0, 1, 0);
        n_cmp++;
        if (outv !== 6'b000001 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL b2b_vend_coin: out=%b cr=%0d, want 000001 cr=0", outv, credit);
        end
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        n_cmp++;
        if (outv !== 6'b100010 || credit !== 6'd4) begin
            n_err++;
            $display("FAIL b2b_vend2: out=%b cr=%0d, want 100010 cr=4", outv, credit);
        end
        drive(0, 0, 0, 0);
        n_cmp++;
        if (outv !== 6'b000000 || credit !== 6'd0) begin
            n_err++;
            $display("FAIL b2b_done: out=%b cr=%0d, want 000000 cr=0", outv, credit);
        end
    endtask

    initial begin
        rst_n = 1; nickel = 0; dime = 0; quarter = 0; cancel = 0;
        @(negedge clk);
        test_reset();
        test_nickels();
        test_change();
        test_max_credit();
        test_refund();
        test_cancel_coin();
        test_reject();
        test_price1();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vending_machine_param.md
VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 The block SHALL have parameter PRICE, default 4, meaning soda price in nickel units (5 cents each), legal range 1..60.
REQ-002 The block SHALL have parameter CREDIT_W, default 6, meaning credit register width; it SHALL satisfy 2^CREDIT_W > PRICE+4.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port nickel_i, input, 1 bit: a 5-cent coin is present this cycle.
REQ-006 The block SHALL have port dime_i, input, 1 bit: a 10-cent coin is present this cycle.
REQ-007 The block SHALL have port quarter_i, input, 1 bit: a 25-cent coin is present this cycle.
REQ-008 The block SHALL have port cancel_i, input, 1 bit: refund request.
REQ-009 The block SHALL have port soda_o, output, 1 bit: dispense one soda.
REQ-010 The block SHALL have port chg_nickel_o, output, 1 bit: eject one nickel this cycle.
REQ-011 The block SHALL have port chg_dime_o, output, 1 bit: eject one dime this cycle.
REQ-012 The block SHALL have port chg_quarter_o, output, 1 bit: eject one quarter this cycle.
REQ-013 The block SHALL have port credit_o, output, CREDIT_W bits: current credit in nickel units.
REQ-014 The block SHALL have port busy_o, output, 1 bit: high in every state except COLLECT.
REQ-015 The block SHALL have port coin_reject_o, output, 1 bit: one-cycle pulse marking that the coin input was rejected.

Function
REQ-016 The FSM SHALL have four states: COLLECT, VEND, CHANGE, REFUND.
REQ-017 All outputs SHALL be Moore outputs of the registered state and credit; no output SHALL depend combinationally on the inputs.
REQ-018 A coin input SHALL be valid only when exactly one of nickel_i, dime_i, quarter_i is high; the valid values are +1, +2 and +5 nickel units respectively.
REQ-019 In COLLECT, a valid coin without cancel_i SHALL add its value to credit at that edge.
REQ-020 In COLLECT, if the new credit is at least PRICE, the block SHALL enter VEND at the same edge; otherwise it SHALL stay in COLLECT.
REQ-021 In VEND, which lasts exactly one cycle, soda_o SHALL be 1; the following edge SHALL subtract PRICE from credit and go to CHANGE if the remainder is greater than 0, else to COLLECT.
REQ-022 Soda latency SHALL be: soda_o high during the cycle immediately after the edge that accepted the completing coin.
REQ-023 CHANGE and REFUND SHALL eject coins greedily, one coin per cycle: quarter if credit >= 5, else dime if credit >= 2, else nickel.
REQ-024 In CHANGE and REFUND, exactly one chg_*_o SHALL be high per cycle, and its value SHALL be subtracted from credit at the next edge.
REQ-025 CHANGE and REFUND SHALL return to COLLECT at the edge where credit reaches 0.
REQ-026 In COLLECT, cancel_i with credit > 0 SHALL enter REFUND and SHALL NOT dispense a soda.
REQ-027 In COLLECT, cancel_i with credit == 0 SHALL be ignored.
REQ-028 If cancel_i and a coin arrive in the same COLLECT cycle, cancel SHALL win: the coin is rejected and credit is unchanged at that edge.
REQ-029 A multi-hot coin input in COLLECT SHALL be rejected with credit unchanged.
REQ-030 Any coin input (valid or multi-hot) while busy SHALL be rejected, and cancel_i while busy SHALL be ignored.
REQ-031 A rejected coin SHALL set coin_reject_o to 1 for the cycle after the sampling edge only.
REQ-032 Credit SHALL never exceed PRICE+4, and arithmetic SHALL never wrap.
REQ-033 soda_o and the chg_*_o outputs SHALL never be high in the same cycle.

Reset
REQ-034 When rst_ni is 0 at a rising edge, the block SHALL force state=COLLECT, credit_o=0, soda_o=0, all chg_*_o=0, busy_o=0, coin_reject_o=0, regardless of the current state.
REQ-035 Reset mid-VEND, mid-CHANGE or mid-REFUND SHALL discard the remaining credit, and no further soda or change SHALL be emitted.
REQ-036 Inputs SHALL be ignored during any cycle in which rst_ni is sampled 0.

Verification (PRICE=4 unless stated)
REQ-037 Four single nickels on consecutive cycles SHALL produce credit_o 1,2,3,4, then soda_o=1 for one cycle, no chg_*_o, then credit_o=0 and busy_o=0.
REQ-038 Nickel then quarter SHALL produce credit 6, then VEND, then one chg_dime_o cycle, then COLLECT with credit 0.
REQ-039 With PRICE=1, a quarter from credit 0 SHALL produce VEND, then chg_dime_o, chg_dime_o on consecutive cycles, then COLLECT.
REQ-040 Dime then cancel_i SHALL produce REFUND with one chg_dime_o cycle and soda_o never asserted.
REQ-041 A 3'b011 coin in COLLECT, and separately a nickel during CHANGE, SHALL each produce a coin_reject_o pulse with credit and state unaffected.
REQ-042 rst_ni=0 during the chg_dime_o cycle of the REQ-038 sequence SHALL give all outputs 0 and credit_o=0 on the next cycle, with no further change ejected.
